// File: rtl/poly_dds_voice_engine.sv
// Polyphonic DDS voice engine: MIDI parser, voice allocator, per-voice phase accumulators
// and a time-multiplexed wavetable mixer. Optional voice stealing: POLY_DDS_VOICE_STEAL_EN.

module poly_dds_voice_engine #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 32,
    parameter int INC_W      = 16,
    parameter int ADDR_W     = 12,
    parameter int SAMPLE_W   = 24,
    parameter int OUT_W      = 8,
    parameter int SAMPLE_DIV = 101
) (
    input  logic                  i_clk,
    input  logic                  i_nreset,
    input  logic [7:0]            i_midi_data,
    input  logic                  i_midi_valid,
    output logic                  o_midi_ready,
    output logic [6:0]            o_inc_note,
    input  logic [INC_W-1:0]      i_inc_value,
    output logic [ADDR_W-1:0]     o_rom_addr,
    input  logic [SAMPLE_W-1:0]   i_rom_data,
    output logic [OUT_W-1:0]      o_sample_out,
    output logic                  o_sample_valid,
    output logic [NUM_VOICES-1:0] o_voice_active,
    output logic                  o_note_drop
);

    localparam int VOICE_W = $clog2(NUM_VOICES);
    localparam int ACC_W   = SAMPLE_W + VOICE_W;
    localparam int DIV_W   = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {P_IDLE, P_NOTE, P_VEL} parse_state_e;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} scan_state_e;

    parse_state_e            r_pstate;
    logic                    r_cmd_on;
    logic [6:0]              r_note_lat;
    logic                    r_ready;

    logic [NUM_VOICES-1:0]   r_active;
    logic [6:0]              r_note  [NUM_VOICES];
    logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
    logic                    r_note_drop;
`ifdef POLY_DDS_VOICE_STEAL_EN
    logic [VOICE_W-1:0]      r_steal_ptr;
`endif

    scan_state_e             r_state;
    logic [DIV_W-1:0]        r_div;
    logic [VOICE_W-1:0]      r_scan_idx;
    logic                    r_drain_cnt;
    logic [ADDR_W-1:0]       r_rom_addr;
    logic                    r_mix_en1;
    logic                    r_mix_en2;
    logic [ACC_W-1:0]        r_acc;
    logic [OUT_W-1:0]        r_sample_out;
    logic                    r_sample_valid;

    logic                    w_accept;
    logic                    w_ev_valid;
    logic                    w_ev_on;
    logic                    w_tick;
    logic                    w_match_hit;
    logic [VOICE_W-1:0]      w_match_idx;
    logic                    w_free_hit;
    logic [VOICE_W-1:0]      w_free_idx;

    assign w_accept   = i_midi_valid & r_ready;
    assign w_ev_valid = w_accept & ~i_midi_data[7] & (r_pstate == P_VEL);
    assign w_ev_on    = r_cmd_on & (i_midi_data[6:0] != 7'd0);
    assign w_tick     = (r_div == DIV_W'(SAMPLE_DIV - 1));

    // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
    always_comb begin
        w_match_hit = 1'b0;
        w_match_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        // Descending scan leaves the lowest-indexed hit in each result.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && (r_note[v] == r_note_lat)) begin
                w_match_hit = 1'b1;
                w_match_idx = VOICE_W'(v);
            end
            if (!r_active[v]) begin
                w_free_hit = 1'b1;
                w_free_idx = VOICE_W'(v);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_ready    <= 1'b0;
            r_pstate   <= P_IDLE;
            r_cmd_on   <= 1'b0;
            r_note_lat <= '0;
        end else begin
            r_ready <= 1'b1;
            if (w_accept) begin
                casez (i_midi_data)
                    8'b1000_????: begin r_cmd_on <= 1'b0; r_pstate <= P_NOTE; end
                    8'b1001_????: begin r_cmd_on <= 1'b1; r_pstate <= P_NOTE; end
                    8'b1???_????: begin r_cmd_on <= 1'b0; r_pstate <= P_IDLE; end
                    default: begin
                        case (r_pstate)
                            P_NOTE: begin
                                r_note_lat <= i_midi_data[6:0];
                                r_pstate   <= P_VEL;
                            end
                            P_VEL:   r_pstate <= P_NOTE;
                            default: r_pstate <= P_IDLE;
                        endcase
                    end
                endcase
            end
        end
    end

    // NOTE: r_note is deliberately left out of reset; occupancy is decided by r_active alone.
    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_active    <= '0;
            r_note_drop <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) r_phase[v] <= '0;
`ifdef POLY_DDS_VOICE_STEAL_EN
            r_steal_ptr <= '0;
`endif
        end else begin
            r_note_drop <= 1'b0;
            if (r_state == S_SCAN && r_active[r_scan_idx])
                r_phase[r_scan_idx] <= r_phase[r_scan_idx] + PHASE_W'(i_inc_value);
            // Parser events come last so they override a same-cycle scan increment.
            if (w_ev_valid) begin
                if (w_ev_on) begin
                    if (w_match_hit) begin
                        r_phase[w_match_idx] <= '0;
                    end else if (w_free_hit) begin
                        r_active[w_free_idx] <= 1'b1;
                        r_note[w_free_idx]   <= r_note_lat;
                        r_phase[w_free_idx]  <= '0;
                    end else begin
`ifdef POLY_DDS_VOICE_STEAL_EN
                        r_note[r_steal_ptr]  <= r_note_lat;
                        r_phase[r_steal_ptr] <= '0;
                        r_steal_ptr          <= r_steal_ptr + VOICE_W'(1);
`else
                        r_note_drop <= 1'b1;
`endif
                    end
                end else if (w_match_hit) begin
                    r_active[w_match_idx] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_state        <= S_IDLE;
            r_div          <= '0;
            r_scan_idx     <= '0;
            r_drain_cnt    <= 1'b0;
            r_rom_addr     <= '0;
            r_mix_en1      <= 1'b0;
            r_mix_en2      <= 1'b0;
            r_acc          <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_div          <= w_tick ? '0 : r_div + DIV_W'(1);
            r_sample_valid <= 1'b0;
            r_mix_en1      <= 1'b0;
            r_mix_en2      <= r_mix_en1;
            // ROM data lags the registered address by one clock, hence two enable stages.
            if (r_mix_en2)
                r_acc <= r_acc + ACC_W'(i_rom_data);
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state    <= S_SCAN;
                        r_scan_idx <= '0;
                    end
                end
                S_SCAN: begin
                    r_rom_addr <= r_phase[r_scan_idx][PHASE_W-1 -: ADDR_W];
                    r_mix_en1  <= r_active[r_scan_idx];
                    if (r_scan_idx == VOICE_W'(NUM_VOICES - 1)) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= 1'b0;
                    end else begin
                        r_scan_idx <= r_scan_idx + VOICE_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt) r_state <= S_DONE;
                    r_drain_cnt <= 1'b1;
                end
                default: begin
                    r_sample_out   <= r_acc[ACC_W-1 -: OUT_W];
                    r_sample_valid <= 1'b1;
                    r_acc          <= '0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign o_midi_ready   = r_ready;
    assign o_inc_note     = r_note[r_scan_idx];
    assign o_rom_addr     = r_rom_addr;
    assign o_sample_out   = r_sample_out;
    assign o_sample_valid = r_sample_valid;
    assign o_voice_active = r_active;
    assign o_note_drop    = r_note_drop;

endmodule

// File: tb/tb_poly_dds_voice_engine.sv
// Directed bench for poly_dds_voice_engine: MIDI parsing, allocation, mixing, timing and reset abort.
// Build with POLY_DDS_VOICE_STEAL_EN defined to cover the voice-stealing variant.

module tb_poly_dds_voice_engine;

    logic        clk = 1'b0;
    logic        nreset;
    logic [7:0]  midi_data;
    logic        midi_valid;
    logic        midi_ready;
    logic [6:0]  inc_note;
    logic [15:0] inc_value;
    logic [11:0] rom_addr;
    logic [23:0] rom_data;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic [7:0]  voice_active;
    logic        note_drop;

    logic [15:0] inc_const;
    int          vectors = 0;
    int          miscompares = 0;
    int          edges = 0;
    int          sv_count = 0;
    int          sv_edge = 0;
    logic [7:0]  sv_last = '0;
    int          drop_count = 0;
    int          d0;
    logic        exp_drop;
    logic [6:0]  exp_note0;

    always #5 clk = ~clk;

    // Test LUT: one increment for every note, with a distinct value for the top note.
    assign inc_value = (inc_note == 7'h7F) ? 16'h0001 : inc_const;

    poly_dds_voice_engine dut (
        .i_clk          (clk),
        .i_nreset       (nreset),
        .i_midi_data    (midi_data),
        .i_midi_valid   (midi_valid),
        .o_midi_ready   (midi_ready),
        .o_inc_note     (inc_note),
        .i_inc_value    (inc_value),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_data),
        .o_sample_out   (sample_out),
        .o_sample_valid (sample_valid),
        .o_voice_active (voice_active),
        .o_note_drop    (note_drop)
    );

    always @(posedge clk) begin
        if (!nreset) edges = 0;
        else         edges = edges + 1;
    end

    always @(negedge clk) begin
        if (sample_valid) begin
            sv_count = sv_count + 1;
            sv_edge  = edges;
            sv_last  = sample_out;
        end
        if (note_drop) drop_count = drop_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset     = 1'b0;
        midi_valid = 1'b0;
        step(3);
        nreset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic accepted;
        accepted   = 1'b0;
        midi_data  = b;
        midi_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = midi_ready;
            step(1);
        end
        midi_valid = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $error("FAIL midi_handshake: byte %0h not accepted, required accept within 20 cycles", b);
        end
    endtask

    task automatic send3(input logic [7:0] s, input logic [7:0] n, input logic [7:0] v);
        send_byte(s);
        send_byte(n);
        send_byte(v);
    endtask

    task automatic wait_pulse();
        int start;
        start = sv_count;
        for (int i = 0; i < 400 && sv_count == start; i++) step(1);
        if (sv_count == start) begin
            vectors++;
            miscompares++;
            $error("FAIL sample_valid_timeout: no pulse in 400 cycles, required one");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset     = 1'b0;
        midi_valid = 1'b0;
        midi_data  = 8'h00;
        rom_data   = 24'hFFFFFF;
        inc_const  = 16'd1024;
`ifdef POLY_DDS_VOICE_STEAL_EN
        exp_drop  = 1'b0;
        exp_note0 = 7'd9;
`else
        exp_drop  = 1'b1;
        exp_note0 = 7'd1;
`endif

        // Reset state and idle sample cadence.
        step(3);
        check("rst_midi_ready", midi_ready, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_voice_active", voice_active, 0);
        check("rst_note_drop", note_drop, 0);
        nreset = 1'b1;
        step(1);
        check("rel_midi_ready", midi_ready, 1);
        wait_pulse();
        check("idle_first_pulse_edge", sv_edge, 112);
        check("idle_sample_out", sv_last, 0);
        wait_pulse();
        check("idle_second_pulse_edge", sv_edge, 213);
        check("idle_voice_active", voice_active, 0);

        // Single note: allocation, phase advance, mix level.
        do_reset();
        send3(8'h90, 8'h3C, 8'h40);
        check("one_voice_active", voice_active, 8'h01);
        check("one_phase_start", dut.r_phase[0], 0);
        wait_pulse();
        check("one_phase_tick1", dut.r_phase[0], 32'd1024);
        check("one_sample_out", sv_last, 8'h1F);
        wait_pulse();
        check("one_phase_tick2", dut.r_phase[0], 32'd2048);

        // Running status, velocity-0 note-off, foreign status, note 0.
        do_reset();
        send3(8'h91, 8'h30, 8'h40);
        check("rs_first", voice_active, 8'h01);
        send_byte(8'h32);
        send_byte(8'h40);
        check("rs_second", voice_active, 8'h03);
        send3(8'h90, 8'h30, 8'h00);
        check("rs_vel0_off", voice_active, 8'h02);
        send3(8'hB0, 8'h10, 8'h40);
        check("rs_foreign_status", voice_active, 8'h02);
        send3(8'h80, 8'h32, 8'h40);
        check("rs_8n_off", voice_active, 8'h00);
        send3(8'h90, 8'h00, 8'h40);
        check("rs_note0_on", voice_active, 8'h01);
        send_byte(8'h55);
        send_byte(8'h00);
        check("rs_off_nomatch", voice_active, 8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        check("rs_note0_off", voice_active, 8'h00);

        // Exhaust all voices, then a ninth note-on.
        do_reset();
        d0 = drop_count;
        for (int n = 1; n <= 8; n++) send3(8'h90, 8'(n), 8'h40);
        check("full_active", voice_active, 8'hFF);
        check("full_no_drop", drop_count - d0, 0);
        send3(8'h90, 8'h09, 8'h40);
        check("ninth_drop_pulse", note_drop, exp_drop);
        check("ninth_voice0_note", dut.r_note[0], exp_note0);
        step(1);
        check("ninth_drop_clears", note_drop, 0);
        check("ninth_active", voice_active, 8'hFF);
        check("ninth_drop_count", drop_count - d0, 32'(exp_drop));
        wait_pulse();
        wait_pulse();
        check("full_sample_out", sv_last, 8'hFF);
        send3(8'h80, 8'h05, 8'h00);
        check("full_off_note5", voice_active, 8'hEF);
        send3(8'h90, 8'h0A, 8'h40);
        check("full_refill_active", voice_active, 8'hFF);
        check("full_refill_voice4", dut.r_note[4], 7'h0A);

        // Retrigger of a held note, including a collision with its own scan cycle.
        do_reset();
        send3(8'h90, 8'h40, 8'h40);
        wait_pulse();
        wait_pulse();
        check("retrig_phase_before", dut.r_phase[0], 32'd2048);
        send3(8'h90, 8'h40, 8'h40);
        check("retrig_phase_zero", dut.r_phase[0], 0);
        check("retrig_active", voice_active, 8'h01);
        wait_pulse();
        check("retrig_phase_after", dut.r_phase[0], 32'd1024);
        send_byte(8'h90);
        send_byte(8'h40);
        step(87);
        send_byte(8'h40);
        check("collide_phase_zero", dut.r_phase[0], 0);
        wait_pulse();
        check("collide_phase_held", dut.r_phase[0], 0);
        check("collide_sample_out", sv_last, 8'h1F);
        wait_pulse();
        check("collide_phase_next", dut.r_phase[0], 32'd1024);

        // Three voices mixed, then reset asserted mid-scan.
        do_reset();
        send3(8'h90, 8'h01, 8'h40);
        send3(8'h90, 8'h02, 8'h40);
        send3(8'h90, 8'h03, 8'h40);
        check("three_active", voice_active, 8'h07);
        wait_pulse();
        check("three_sample_out", sv_last, 8'h5F);
        step(91);
        nreset = 1'b0;
        step(1);
        check("abort_voice_active", voice_active, 0);
        check("abort_sample_out", sample_out, 0);
        check("abort_sample_valid", sample_valid, 0);
        check("abort_rom_addr", rom_addr, 0);
        check("abort_midi_ready", midi_ready, 0);
        check("abort_note_drop", note_drop, 0);
        nreset = 1'b1;
        wait_pulse();
        check("abort_next_pulse_edge", sv_edge, 112);
        check("abort_next_sample", sv_last, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/poly_dds_voice_engine.md
# poly_dds_voice_engine

Parametrised polyphonic DDS voice engine: parses a MIDI byte stream (from the SPI slave's streaming source) into note-on/note-off events, allocates them to NUM_VOICES voices, advances one phase accumulator per voice at the audio sample rate, time-multiplexes a single synchronous wavetable ROM across voices, and mixes the results into one sample for the R2R DAC. It sits between `spi_slave` and the DAC output register and generalises the fixed 8-voice engine in voice count, widths, sample rate, MIDI parsing and voice allocation.

## Interface
- NUM_VOICES, 8: voice count, power of two, 2..32.
- PHASE_W, 32: phase accumulator width.
- INC_W, 16: phase increment width, INC_W ≤ PHASE_W.
- ADDR_W, 12: wavetable address width, equal to phase[PHASE_W-1 -: ADDR_W].
- SAMPLE_W, 24: ROM sample width, unsigned.
- OUT_W, 8: mixed output width.
- SAMPLE_DIV, 101: clocks per sample tick, ≥ NUM_VOICES+4.

- clk  in  1  system clock.
- nreset  in  1  synchronous, active-low reset.
- midi_data  in  8  MIDI byte.
- midi_valid  in  1  byte present.
- midi_ready  out  1  byte accepted when valid&ready.
- inc_note  out  7  note index to external increment LUT.
- inc_value  in  INC_W  combinational LUT result for inc_note, same cycle.
- rom_addr  out  ADDR_W  registered wavetable address.
- rom_data  in  SAMPLE_W  ROM output, one clock after rom_addr.
- sample_out  out  OUT_W  mixed sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- voice_active  out  NUM_VOICES  per-voice busy flags (LED drive).
- note_drop  out  1  one-cycle pulse when a note-on is dropped.

## Operation
- Reset: all voices inactive, phases 0, parser IDLE, FSM IDLE, divider 0; sample_out, sample_valid, rom_addr, note_drop, voice_active = 0; midi_ready = 0 during reset, 1 from the first cycle after release, then held 1.
- Parser states IDLE, NOTE, VEL. Status byte (bit7=1): 0x8n → cmd=OFF, 0x9n → cmd=ON, next state NOTE; low nibble ignored (omni). Any other status byte → IDLE, cmd cleared. Data byte in IDLE ignored; in NOTE latch note, → VEL; in VEL apply event, → NOTE (running status).
- 0x9n with velocity 0 is a note-off.
- Note-on, note already held by voice v: retrigger, phase[v]=0, no allocation. Otherwise the lowest-indexed inactive voice gets the note, phase=0, active=1. All voices busy: see Configuration.
- Note-off: clear active on the voice holding the note; no match → ignored. Note 0 is a legal note; occupancy is the active bit only.
- Sample FSM IDLE → SCAN → DRAIN → DONE → IDLE. Tick when divider == SAMPLE_DIV-1 (divider then wraps to 0).
- SCAN, cycle k (k=0..NUM_VOICES-1): inc_note=note[k]; rom_addr ← top ADDR_W bits of pre-update phase[k]; if active, phase[k] ← phase[k] + zero-extended inc_value (modulo 2^PHASE_W wrap); inactive phases hold.
- rom_data for voice k is accumulated at cycle k+2; inactive voices contribute 0. Accumulator width SAMPLE_W+log2(NUM_VOICES), no saturation.
- DRAIN 2 cycles; DONE: sample_out ← accumulator[top OUT_W bits], sample_valid=1, accumulator cleared.
- Parser event and SCAN update of the same voice in the same cycle: the event wins (phase=0), scan increment discarded; active state sampled for mixing is the one at that voice's SCAN cycle.

## Timing
- Tick cycle T: FSM enters SCAN at T+1; sample_valid at T+NUM_VOICES+4; sample_out held until next DONE.
- Event applied the cycle after the velocity byte handshake; voice_active reflects it the same cycle.
- note_drop pulses in the event-apply cycle.
- Reset asserted mid-SCAN aborts the sample; no sample_valid for that tick.

## Configuration
- POLY_DDS_VOICE_STEAL_EN defined: note-on with all voices busy steals the voice at a round-robin pointer (reset 0, increments modulo NUM_VOICES on each steal), phase=0, note_drop not asserted.
- Undefined: the note-on is dropped, note_drop pulses, no voice changes.

## Test plan
- Reset, no MIDI, rom_data=24'hFFFFFF: sample_valid every 101 clocks, sample_out=0, voice_active=0.
- Bytes 0x90,0x3C,0x40, inc_value=1024, rom_data=24'hFFFFFF: voice_active=8'h01; phase[0] advances 1024 per tick; sample_out=8'h1F.
- Running status 0x91,0x30,0x40,0x32,0x40 then 0x90,0x30,0x00: voice_active goes 01→03→02.
- Nine note-ons 0x90,n,0x40 (n=1..9): without macro voice_active=8'hFF, one note_drop pulse on n=9; with macro voice 0 holds note 9, no drop.
- Note-on for held note while its phase=0x8000_0000: phase reset to 0, voice_active unchanged.
- nreset low 1 cycle mid-SCAN with 3 active voices: all outputs 0 next cycle, no sample_valid until next full tick.
